// File: rtl/rsfq_split_n_clocked.sv
// Clock-sampled N-way SFQ splitter with critical-timing hold-off and sticky fault.
// Optional macro SPLIT_ERR_CNT_EN adds an 8-bit saturating dropped-event counter.
module rsfq_split_n_clocked #(
  parameter int N_OUT      = 2,
  parameter int LATENCY    = 3,
  parameter int CT_CYCLES  = 4,
  parameter int PULSE_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             err_clr,
  output logic [N_OUT-1:0] q,
  output logic             busy,
  output logic             err
`ifdef SPLIT_ERR_CNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  localparam int CW = (CT_CYCLES > 0) ?
    $clog2(CT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t             st;
  logic               a_d;
  logic               ev;
  logic               push;
  logic               drop;
  logic [CW-1:0]      cnt;
  logic [LATENCY-1:0] pipe;

  // Toggle detection against the previously sampled input level
  assign ev = a ^ a_d;

  // Accept only in IDLE; anything else coinciding with an event is dropped
  always_comb begin
    push = 1'b0;
    drop = 1'b0;
    if (ev) begin
      if (!err_clr && st == IDLE) push = 1'b1;
      else                        drop = 1'b1;
    end
  end

  // Control FSM: hold-off window, sticky fault, input history, event pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      a_d  <= a;
      st   <= IDLE;
      cnt  <= '0;
      busy <= 1'b0;
      err  <= 1'b0;
      pipe <= '0;
    end else begin
      a_d <= a;
      for (int i = LATENCY - 1; i > 0; i--)
        pipe[i] <= pipe[i-1];
      pipe[0] <= push;
      if (err_clr) begin
        st   <= IDLE;
        cnt  <= '0;
        busy <= 1'b0;
        err  <= 1'b0;
      end else begin
        unique case (st)
          IDLE: begin
            if (ev && CT_CYCLES > 0) begin
              st   <= HOLD;
              cnt  <= CW'(CT_CYCLES);
              busy <= 1'b1;
            end
          end
          HOLD: begin
            if (ev) begin
              st   <= FAULT;
              cnt  <= '0;
              busy <= 1'b0;
              err  <= 1'b1;
            end else if (cnt == CW'(1)) begin
              st   <= IDLE;
              cnt  <= '0;
              busy <= 1'b0;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          FAULT: begin
            st <= FAULT;
          end
          default: begin
            st   <= IDLE;
            cnt  <= '0;
            busy <= 1'b0;
          end
        endcase
      end
    end
  end

  // Output stage: toggle all branches, or a one-cycle all-ones pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (PULSE_MODE != 0) begin
      q <= {N_OUT{pipe[LATENCY-1]}};
    end else if (pipe[LATENCY-1]) begin
      q <= ~q;
    end
  end

`ifdef SPLIT_ERR_CNT_EN
  // Saturating count of every dropped event; only reset clears it
  always_ff @(posedge clk) begin
    if (rst)
      err_cnt <= '0;
    else if (drop && err_cnt != 8'hFF)
      err_cnt <= err_cnt + 8'd1;
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_rsfq_split_n_clocked.sv
// Directed bench for rsfq_split_n_clocked: toggle and pulse-mode instances.
// Expected values are hand-derived from the event timing rules.
module tb_rsfq_split_n_clocked;

  logic       clk = 1'b0;
  logic       rst, a, err_clr;
  logic [1:0] q;
  logic       busy, err;
  logic       rst2, a2, clr2;
  logic [3:0] q2;
  logic       busy2, err2;
  int         errors = 0;
  int         checks = 0;
`ifdef SPLIT_ERR_CNT_EN
  logic [7:0] err_cnt, err_cnt2;
`endif

  always #5 clk = ~clk;

  rsfq_split_n_clocked dut (
    .clk(clk), .rst(rst), .a(a), .err_clr(err_clr),
    .q(q), .busy(busy), .err(err)
`ifdef SPLIT_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  rsfq_split_n_clocked #(
    .N_OUT(4), .LATENCY(3), .CT_CYCLES(4), .PULSE_MODE(1)
  ) dut2 (
    .clk(clk), .rst(rst2), .a(a2), .err_clr(clr2),
    .q(q2), .busy(busy2), .err(err2)
`ifdef SPLIT_ERR_CNT_EN
    , .err_cnt(err_cnt2)
`endif
  );

  task automatic step(int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1; a = 1; err_clr = 0;
    rst2 = 1; a2 = 0; clr2 = 0;
    step(2);
    chk("rst_q", 32'(q), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("steady_q", 32'(q), 0);
    end
    chk("steady_err", 32'(err), 0);
    chk("steady_busy", 32'(busy), 0);

    // single event: 0 -> 1 at edge k
    rst = 1; a = 0; step(); rst = 0;
    a = 1; step();
    chk("s_busy_k", 32'(busy), 1);
    chk("s_q_k", 32'(q), 0);
    step(2);
    chk("s_busy_k2", 32'(busy), 1);
    chk("s_q_k2", 32'(q), 0);
    step();
    chk("s_q_k3", 32'(q), 2'b11);
    chk("s_busy_k3", 32'(busy), 1);
    step();
    chk("s_busy_k4", 32'(busy), 0);
    chk("s_q_k4", 32'(q), 2'b11);

    // events at k and k+5: both legal
    rst = 1; step(); rst = 0;
    a = 0; step();
    step(2);
    chk("l_q_k2", 32'(q), 0);
    step();
    chk("l_q_k3", 32'(q), 2'b11);
    step();
    chk("l_busy_k4", 32'(busy), 0);
    a = 1; step();
    chk("l_busy_k5", 32'(busy), 1);
    step(2);
    chk("l_q_k7", 32'(q), 2'b11);
    step();
    chk("l_q_k8", 32'(q), 2'b00);
    chk("l_err", 32'(err), 0);

    // events at k and k+4: violation
    rst = 1; step(); rst = 0;
    a = 0; step();
    step(3);
    chk("v_q_k3", 32'(q), 2'b11);
    chk("v_err_k3", 32'(err), 0);
    a = 1; step();
    chk("v_err_k4", 32'(err), 1);
    chk("v_busy_k4", 32'(busy), 0);
    step(5);
    chk("v_q_k9", 32'(q), 2'b11);
    a = 0; step();
    step(5);
    chk("v_q_ign", 32'(q), 2'b11);
    chk("v_err_sticky", 32'(err), 1);
`ifdef SPLIT_ERR_CNT_EN
    chk("v_err_cnt", 32'(err_cnt), 2);
`endif

    // err_clr with coincident toggle: toggle dropped
    err_clr = 1; a = 1; step();
    err_clr = 0;
    chk("c_err", 32'(err), 0);
    chk("c_busy", 32'(busy), 0);
    chk("c_q", 32'(q), 2'b11);
`ifdef SPLIT_ERR_CNT_EN
    chk("c_err_cnt", 32'(err_cnt), 3);
`endif
    a = 0; step();
    chk("c_busy_acc", 32'(busy), 1);
    step(2);
    chk("c_q_j2", 32'(q), 2'b11);
    step();
    chk("c_q_j3", 32'(q), 2'b00);
    chk("c_err_end", 32'(err), 0);

    // pulse mode, 4 branches
    rst2 = 0;
    chk("p_rst_q", 32'(q2), 0);
    a2 = 1; step();
    chk("p_q_k", 32'(q2), 0);
    step(2);
    chk("p_q_k2", 32'(q2), 0);
    step();
    chk("p_q_k3", 32'(q2), 4'hF);
    step();
    chk("p_q_k4", 32'(q2), 0);
    step(4);
    chk("p_err", 32'(err2), 0);

    // reset mid-flight discards the event
    a2 = 0; step();
    rst2 = 1; step(); rst2 = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("p_rst_flush", 32'(q2), 0);
    end
    chk("p_rst_busy", 32'(busy2), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
